// File: rtl/tft_spi_receiver_pkg.sv
// Shared TFT command constants and the init-register ROM used by the transmitter and receiver.
package tft_spi_receiver_pkg;

  localparam int unsigned WordBitsDef = 16;

  localparam logic [7:0] CmdSwreset = 8'h01;
  localparam logic [7:0] CmdSlpout  = 8'h11;
  localparam logic [7:0] CmdDispon  = 8'h29;
  localparam logic [7:0] CmdCaset   = 8'h2A;
  localparam logic [7:0] CmdRaset   = 8'h2B;
  localparam logic [7:0] CmdRamwr   = 8'h2C;

  localparam logic [7:0] RamwrCmdDef = CmdRamwr;

  typedef struct packed {
    logic        isData;
    logic [15:0] word;
  } tft_word_t;

  localparam int unsigned InitRomDepth = 10;

  function automatic tft_word_t initRom(input int unsigned idx);
    tft_word_t w;
    case (idx)
      0:       w = '{isData: 1'b0, word: {8'h00, CmdSwreset}};
      1:       w = '{isData: 1'b0, word: {8'h00, CmdSlpout}};
      2:       w = '{isData: 1'b0, word: {8'h00, CmdCaset}};
      3:       w = '{isData: 1'b1, word: 16'h0000};
      4:       w = '{isData: 1'b1, word: 16'h007F};
      5:       w = '{isData: 1'b0, word: {8'h00, CmdRaset}};
      6:       w = '{isData: 1'b1, word: 16'h0000};
      7:       w = '{isData: 1'b1, word: 16'h009F};
      8:       w = '{isData: 1'b0, word: {8'h00, CmdDispon}};
      default: w = '{isData: 1'b0, word: {8'h00, CmdRamwr}};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tft_spi_receiver_if.sv
// SPI pins plus the received-word stream of the TFT SPI receiver.
interface tft_spi_receiver_if #(
  parameter int unsigned WORD_BITS    = 16,
  parameter int unsigned PIX_CNT_BITS = 24
);
  logic                    SPI_CLK;
  logic                    SPI_MOSI;
  logic                    SPI_CS;
  logic                    RS;
  logic [WORD_BITS-1:0]    RxData;
  logic                    RxIsData;
  logic                    RxValid;
  logic                    RxReady;
  logic [7:0]              LastCmd;
  logic [PIX_CNT_BITS-1:0] PixelCount;
  logic                    Overrun;
  logic                    FrameError;

  modport master (
    input  SPI_CLK, SPI_MOSI, SPI_CS, RS, RxReady,
    output RxData, RxIsData, RxValid, LastCmd, PixelCount, Overrun, FrameError
  );

  modport slave (
    output SPI_CLK, SPI_MOSI, SPI_CS, RS, RxReady,
    input  RxData, RxIsData, RxValid, LastCmd, PixelCount, Overrun, FrameError
  );
endinterface

// File: rtl/tft_spi_receiver_sync_edge.sv
// Two-flop synchroniser with registered rising/falling edge detect; q is delayed one more
// stage so that it lines up with the edge strobes.
module tft_spi_receiver_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic meta, sync, dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= ResetVal;
      sync <= ResetVal;
      dly  <= ResetVal;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      dly  <= sync;
      rise <= sync & ~dly;
      fall <= ~sync & dly;
    end
  end

  assign q = dly;
endmodule

// File: rtl/tft_spi_receiver.sv
// TFT SPI receiver: deserialises mode-0 SPI words into a one-entry valid/ready holding register
// and tracks the last command plus the pixel count following RAMWR.
module tft_spi_receiver
  import tft_spi_receiver_pkg::*;
#(
  parameter int unsigned WORD_BITS    = WordBitsDef,
  parameter logic [7:0]  RAMWR_CMD    = RamwrCmdDef,
  parameter int unsigned PIX_CNT_BITS = 24
) (
  input logic MasterCLK,
  input logic Reset,
  tft_spi_receiver_if.master bus
);
  localparam int unsigned CntBits = $clog2(WORD_BITS);

  logic sclkQ, sclkRise, sclkFall;
  logic mosi, mosiRise, mosiFall;
  logic rs, rsRise, rsFall;
  logic csHigh, csRise, csFall;
  logic unusedEdges;

  tft_spi_receiver_sync_edge #(.ResetVal(1'b0)) uSclk (
    .clk(MasterCLK), .rst(Reset), .d(bus.SPI_CLK), .q(sclkQ), .rise(sclkRise), .fall(sclkFall)
  );
  tft_spi_receiver_sync_edge #(.ResetVal(1'b0)) uMosi (
    .clk(MasterCLK), .rst(Reset), .d(bus.SPI_MOSI), .q(mosi), .rise(mosiRise), .fall(mosiFall)
  );
  tft_spi_receiver_sync_edge #(.ResetVal(1'b0)) uRs (
    .clk(MasterCLK), .rst(Reset), .d(bus.RS), .q(rs), .rise(rsRise), .fall(rsFall)
  );
  tft_spi_receiver_sync_edge #(.ResetVal(1'b1)) uCs (
    .clk(MasterCLK), .rst(Reset), .d(bus.SPI_CS), .q(csHigh), .rise(csRise), .fall(csFall)
  );

  assign unusedEdges = ^{sclkQ, sclkFall, mosiRise, mosiFall, rsRise, rsFall, csFall};

  logic [WORD_BITS-2:0]    shiftReg;
  logic [CntBits-1:0]      bitCnt;
  logic [WORD_BITS-1:0]    rxData;
  logic                    rxIsData, rxValid, overrun, frameErr;
  logic [7:0]              lastCmd;
  logic [PIX_CNT_BITS-1:0] pixCnt;

  logic [WORD_BITS-1:0] newWord;
  logic                 shiftEn, wordDone, loadEn;

  always_comb begin
    newWord  = {shiftReg, mosi};
    shiftEn  = sclkRise & ~csHigh;
    wordDone = shiftEn & (bitCnt == CntBits'(WORD_BITS - 1));
    loadEn   = wordDone & (~rxValid | bus.RxReady);
  end

  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      rxData   <= '0;
      rxIsData <= 1'b0;
      rxValid  <= 1'b0;
      overrun  <= 1'b0;
      frameErr <= 1'b0;
      lastCmd  <= 8'h00;
      pixCnt   <= '0;
    end else begin
      frameErr <= 1'b0;
      if (csHigh) begin
        // bitCnt still holds the partial count in the cycle the CS rise is seen
        frameErr <= csRise & (bitCnt != '0);
        bitCnt   <= '0;
      end else if (shiftEn) begin
        shiftReg <= newWord[WORD_BITS-2:0];
        bitCnt   <= wordDone ? '0 : bitCnt + 1'b1;
      end

      if (loadEn) begin
        rxData   <= newWord;
        rxIsData <= rs;
        rxValid  <= 1'b1;
        if (!rs) begin
          lastCmd <= newWord[7:0];
          pixCnt  <= '0;
        end else if (lastCmd == RAMWR_CMD && pixCnt != {PIX_CNT_BITS{1'b1}}) begin
          pixCnt <= pixCnt + 1'b1;
        end
      end else if (wordDone) begin
        overrun <= 1'b1;
      end else if (rxValid && bus.RxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

  assign bus.RxData     = rxData;
  assign bus.RxIsData   = rxIsData;
  assign bus.RxValid    = rxValid;
  assign bus.LastCmd    = lastCmd;
  assign bus.PixelCount = pixCnt;
  assign bus.Overrun    = overrun;
  assign bus.FrameError = frameErr;
endmodule
